hpu_csr: RTL and testbench

HPU_CSR -- requirements
Module: hpu_csr

---
 rtl/hpu_pkg.sv | 37 +++
 rtl/hpu_axil_fsm.sv | 93 +++++++++
 rtl/hpu_csr.sv | 184 ++++++++++++++++++
 tb/tb_hpu_csr.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared constants for the HPU control/status block: register offsets,
// AXI-Lite handshake state encoding and the reset defaults of the job registers.
package hpu_pkg;

  localparam int unsigned REG_CTRL    = 32'h00;
  localparam int unsigned REG_STATUS  = 32'h04;
  localparam int unsigned REG_NGRAM   = 32'h08;
  localparam int unsigned REG_ITER    = 32'h0C;
  localparam int unsigned REG_CONTROL = 32'h10;
  localparam int unsigned REG_ITEM    = 32'h14;
  localparam int unsigned REG_IRQ_EN  = 32'h18;

  localparam int unsigned NGRAM_RST = 2;
  localparam int unsigned ITER_RST  = 7;
  localparam int unsigned ITEM_RST  = 99;

  typedef enum logic [2:0] {
    ST_INI,
    ST_AW,
    ST_W,
    ST_AWW,
    ST_AR1,
    ST_AR2
  } axil_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hpu_axil_fsm.sv
// AXI-Lite slave handshake FSM: captures write address/data and read address,
// emits a one-cycle write commit on AWW entry and a read-load strobe in AR1.
module hpu_axil_fsm
  import hpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        rd_en,
  output logic [31:0] rd_addr
);

  axil_state_e state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] araddr_q, araddr_d;
  logic        aww_first_q, aww_first_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INI: begin
        if (awvalid && wvalid) state_d = ST_AWW;
        else if (awvalid)      state_d = ST_AW;
        else if (wvalid)       state_d = ST_W;
        else if (arvalid)      state_d = ST_AR1;
      end
      ST_AW:   if (wvalid)  state_d = ST_AWW;
      ST_W:    if (awvalid) state_d = ST_AWW;
      ST_AWW:  if (bready)  state_d = ST_INI;
      ST_AR1:  state_d = ST_AR2;
      ST_AR2:  if (rready)  state_d = ST_INI;
      default: state_d = ST_INI;
    endcase

    awready = (state_q == ST_INI) || (state_q == ST_W);
    wready  = (state_q == ST_INI) || (state_q == ST_AW);
    arready = (state_q == ST_INI);
    bvalid  = (state_q == ST_AWW);
    rvalid  = (state_q == ST_AR2);

    awaddr_d = (awvalid && awready) ? awaddr : awaddr_q;
    wdata_d  = (wvalid && wready)   ? wdata  : wdata_q;
    wstrb_d  = (wvalid && wready)   ? wstrb  : wstrb_q;
    araddr_d = (arvalid && arready) ? araddr : araddr_q;
    // Commit exactly once, even if BREADY is held off and AWW lasts several cycles.
    aww_first_d = (state_d == ST_AWW) && (state_q != ST_AWW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INI;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      aww_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      aww_first_q <= aww_first_d;
    end
  end

  assign wr_en   = aww_first_q;
  assign wr_addr = awaddr_q;
  assign wr_data = wdata_q;
  assign wr_strb = wstrb_q;
  assign rd_en   = (state_q == ST_AR1);
  assign rd_addr = araddr_q;

endmodule

// File: rtl/hpu_csr.sv
// HPU control/status registers behind AXI-Lite, plus the item-memory word counter.
// Optional interrupt output enabled by defining HPU_CSR_IRQ_EN.
module hpu_csr
  import hpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NGRAM_W  = 20,
  parameter int unsigned ITEM_W   = 16,
  parameter int unsigned CORE_NUM = 1
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [31:0]        S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic [3:0]         S_AXI_WSTRB,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [31:0]        S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  input  logic               mat_step,
  input  logic               done_pulse,
  output logic               run,
  output logic               matw,
  output logic               last,
  output logic [NGRAM_W-1:0] addr_j,
  output logic [NGRAM_W-1:0] addr_i,
  output logic [ITEM_W-1:0]  item_num,
`ifdef HPU_CSR_IRQ_EN
  output logic               irq,
`endif
  output logic [ITEM_W-1:0]  mat_a
);

  logic        wr_en, rd_en;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;

  hpu_axil_fsm u_fsm (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .araddr  (S_AXI_ARADDR),
    .arvalid (S_AXI_ARVALID),
    .arready (S_AXI_ARREADY),
    .rvalid  (S_AXI_RVALID),
    .rready  (S_AXI_RREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr)
  );

  // Bits above the decoded window must be zero, so aliases read as unmapped.
  function automatic logic hit(input logic [31:0] a, input int unsigned off);
    return (a[31:ADDR_W] == '0) && (a[ADDR_W-1:0] == ADDR_W'(off));
  endfunction

  logic               run_q, run_d, matw_q, matw_d, last_q, last_d, done_q, done_d;
  logic [NGRAM_W-1:0] addr_j_q, addr_j_d, addr_i_q, addr_i_d;
  logic [ITEM_W-1:0]  item_num_q, item_num_d, mat_a_q, mat_a_d;
  logic [31:0]        control_q, control_d, rdata_q, rdata_d;
`ifdef HPU_CSR_IRQ_EN
  logic               irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  always_comb begin
    run_d      = run_q;
    matw_d     = matw_q;
    last_d     = last_q;
    done_d     = done_q;
    addr_j_d   = addr_j_q;
    addr_i_d   = addr_i_q;
    item_num_d = item_num_q;
    control_d  = control_q;

    if (matw_q && mat_step && (mat_a_q == item_num_q)) matw_d = 1'b0;
    if (wr_en && hit(wr_addr, REG_CTRL) && wr_strb[0]) {last_d, run_d, matw_d} = wr_data[2:0];

    mat_a_d = matw_q ? (mat_step ? mat_a_q + ITEM_W'(1) : mat_a_q) : '0;

    if (wr_en && !run_q) begin
      if (hit(wr_addr, REG_NGRAM))
        addr_j_d = NGRAM_W'(apply_strb(32'(addr_j_q), wr_data, wr_strb));
      if (hit(wr_addr, REG_ITER))
        addr_i_d = NGRAM_W'(apply_strb(32'(addr_i_q), wr_data, wr_strb));
      if (hit(wr_addr, REG_ITEM))
        item_num_d = ITEM_W'(apply_strb(32'(item_num_q), wr_data, wr_strb));
    end
    if (wr_en && hit(wr_addr, REG_CONTROL))
      control_d = apply_strb(control_q, wr_data, wr_strb);

    if (wr_en && hit(wr_addr, REG_STATUS) && wr_strb[0] && wr_data[2]) done_d = 1'b0;
    if (done_pulse) done_d = 1'b1;

`ifdef HPU_CSR_IRQ_EN
    irq_en_d = irq_en_q;
    if (wr_en && hit(wr_addr, REG_IRQ_EN) && wr_strb[0]) irq_en_d = wr_data[0];
    irq_d = done_d & irq_en_d;
`endif

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      if (hit(rd_addr, REG_CTRL))         rdata_d[2:0] = {last_q, run_q, matw_q};
      else if (hit(rd_addr, REG_STATUS))  rdata_d = {16'h0, 8'(CORE_NUM), 5'h0, done_q, run_q, matw_q};
      else if (hit(rd_addr, REG_NGRAM))   rdata_d = 32'(addr_j_q);
      else if (hit(rd_addr, REG_ITER))    rdata_d = 32'(addr_i_q);
      else if (hit(rd_addr, REG_CONTROL)) rdata_d = control_q;
      else if (hit(rd_addr, REG_ITEM))    rdata_d = 32'(item_num_q);
`ifdef HPU_CSR_IRQ_EN
      else if (hit(rd_addr, REG_IRQ_EN))  rdata_d[0] = irq_en_q;
`endif
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      run_q      <= 1'b0;
      matw_q     <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_j_q   <= NGRAM_W'(NGRAM_RST);
      addr_i_q   <= NGRAM_W'(ITER_RST);
      item_num_q <= ITEM_W'(ITEM_RST);
      mat_a_q    <= '0;
      control_q  <= '0;
      rdata_q    <= '0;
`ifdef HPU_CSR_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      run_q      <= run_d;
      matw_q     <= matw_d;
      last_q     <= last_d;
      done_q     <= done_d;
      addr_j_q   <= addr_j_d;
      addr_i_q   <= addr_i_d;
      item_num_q <= item_num_d;
      mat_a_q    <= mat_a_d;
      control_q  <= control_d;
      rdata_q    <= rdata_d;
`ifdef HPU_CSR_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign S_AXI_RDATA = rdata_q;
  assign run         = run_q;
  assign matw        = matw_q;
  assign last        = last_q;
  assign addr_j      = addr_j_q;
  assign addr_i      = addr_i_q;
  assign item_num    = item_num_q;
  assign mat_a       = mat_a_q;
`ifdef HPU_CSR_IRQ_EN
  assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_hpu_csr.sv
// Directed bench for hpu_csr: AXI-Lite register access, mat_a counter, done/irq, reset.
module tb_hpu_csr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic        mat_step = 1'b0, done_pulse = 1'b0;
  logic        run, matw, last;
  logic [19:0] addr_j, addr_i;
  logic [15:0] item_num, mat_a;
`ifdef HPU_CSR_IRQ_EN
  logic        irq;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  hpu_csr #(.ADDR_W(12), .NGRAM_W(20), .ITEM_W(16), .CORE_NUM(1)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .mat_step      (mat_step),
    .done_pulse    (done_pulse),
    .run           (run),
    .matw          (matw),
    .last          (last),
    .addr_j        (addr_j),
    .addr_i        (addr_i),
    .item_num      (item_num),
`ifdef HPU_CSR_IRQ_EN
    .irq           (irq),
`endif
    .mat_a         (mat_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge once the write response has been taken.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (!awvalid && !wvalid) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk);
    check("bvalid_wait", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    logic hs;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      hs = arready;
      @(negedge clk);
      if (hs) break;
    end
    arvalid = 1'b0;
    for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
    check("rvalid_wait", 32'(rvalid), 32'd1);
    d = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_ctrl", {29'd0, last, run, matw}, 32'd0);
    check("rst_addr_j", 32'(addr_j), 32'd2);
    check("rst_addr_i", 32'(addr_i), 32'd7);
    check("rst_item_num", 32'(item_num), 32'd99);
    check("rst_mat_a", 32'(mat_a), 32'd0);
    axi_read(32'h04, rd); check("rst_status", rd, 32'h0000_0100);
    axi_read(32'h18, rd); check("rst_irq_en", rd, 32'h0);

    // Byte strobes on NGRAM
    axi_write(32'h08, 32'd5, 4'b0001);
    axi_read(32'h08, rd); check("ngram_lane0", rd, 32'd5);
    check("addr_j_5", 32'(addr_j), 32'd5);
    axi_write(32'h08, 32'd9, 4'b0000);
    axi_read(32'h08, rd); check("ngram_nostrb", rd, 32'd5);
    axi_write(32'h08, 32'h00AA_BB01, 4'b0110);
    axi_read(32'h08, rd); check("ngram_lane12", rd, 32'h000A_BB05);

    // AW three cycles ahead of W
    awaddr = 32'h10; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("aw_only_bvalid", 32'(bvalid), 32'd0);
      @(negedge clk);
    end
    check("aw_only_wready", 32'(wready), 32'd1);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("aw_w_bvalid", 32'(bvalid), 32'd1);
    check("aw_w_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("aw_w_bvalid_drop", 32'(bvalid), 32'd0);
    axi_read(32'h10, rd); check("control_rd", rd, 32'hDEAD_BEEF);

    // Unmapped and out-of-range addresses
    axi_write(32'h1C, 32'h1234, 4'hF);
    axi_read(32'h1C, rd); check("unmapped_1c", rd, 32'h0);
    axi_read(32'h24, rd); check("above_20", rd, 32'h0);

    // mat_a counting and matw self-clear
    axi_write(32'h14, 32'd3, 4'hF);
    check("item_num_3", 32'(item_num), 32'd3);
    axi_write(32'h00, 32'd1, 4'hF);
    check("matw_set", 32'(matw), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("mat_a_step", 32'(mat_a), 32'(k));
      mat_step = 1'b1;
      @(negedge clk);
      mat_step = 1'b0;
    end
    check("matw_selfclr", 32'(matw), 32'd0);
    @(negedge clk);
    check("mat_a_clr", 32'(mat_a), 32'd0);

    // Job registers locked while running; done sticky
    axi_write(32'h00, 32'd2, 4'hF);
    check("run_set", 32'(run), 32'd1);
    axi_write(32'h0C, 32'd12, 4'hF);
    check("iter_locked", 32'(addr_i), 32'd7);
    axi_write(32'h08, 32'd1, 4'hF);
    check("ngram_locked", 32'(addr_j), 32'h000A_BB05);
`ifdef HPU_CSR_IRQ_EN
    axi_write(32'h18, 32'd1, 4'hF);
`endif
    done_pulse = 1'b1;
    @(negedge clk);
    done_pulse = 1'b0;
    axi_read(32'h04, rd); check("status_done", rd, 32'h0000_0106);
`ifdef HPU_CSR_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
`endif
    axi_write(32'h04, 32'h4, 4'h1);
    axi_read(32'h04, rd); check("status_w1c", rd, 32'h0000_0102);

    // done_pulse coinciding with the W1C commit cycle
    awaddr = 32'h04; wdata = 32'h4; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("w1c_race_bvalid", 32'(bvalid), 32'd1);
    done_pulse = 1'b1; bready = 1'b1;
    @(negedge clk);
    done_pulse = 1'b0; bready = 1'b0;
    axi_read(32'h04, rd); check("done_set_wins", rd, 32'h0000_0106);

    // Reset in the middle of a read response
    axi_write(32'h00, 32'd6, 4'hF);
    check("last_set", 32'(last), 32'd1);
    araddr = 32'h10; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check("ar2_rvalid", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rvalid_drop", 32'(rvalid), 32'd0);
    check("rst2_ctrl", {29'd0, last, run, matw}, 32'd0);
    check("rst2_addr_j", 32'(addr_j), 32'd2);
    check("rst2_addr_i", 32'(addr_i), 32'd7);
    check("rst2_item_num", 32'(item_num), 32'd99);
    check("rst2_rdata", rdata, 32'h0);
`ifdef HPU_CSR_IRQ_EN
    check("rst2_irq", 32'(irq), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(32'h10, rd); check("rst2_control", rd, 32'h0);
    axi_read(32'h04, rd); check("rst2_status", rd, 32'h0000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
